// File: rtl/order_decoder_pkg.sv
// Shared definitions for the order decoder: fixed field positions of the
// 18-bit order word, the control FSM state encoding and the default
// legal-opcode mask.
package order_decoder_pkg;

    localparam int ORDER_BITS = 18;

    // Field positions within the captured order word.
    localparam int OP_LSB    = 13;  // opcode    [17:13]
    localparam int SPARE_BIT = 12;  // spare     [12]
    localparam int TANK_LSB  = 7;   // tank_num  [11:7]
    localparam int POS_LSB   = 3;   // position  [6:3]
    localparam int HALF_BIT  = 2;   // half_mc   [2]
    localparam int LONG_BIT  = 1;   // long_num  [1]

    localparam logic [31:0] DEFAULT_LEGAL_MASK = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_capture.sv
// Serial capture: LSB-first shift register plus bit counter.
//   clk, rst     : clock, synchronous active-high reset
//   start        : current bit is bit 0; discard any partial word, counter = 1
//   shift_en     : sample one more bit
//   clear        : discard partial word, counter = 0
//   bit_in       : serial data
//   shifted_word : register contents with bit_in shifted in (the complete
//                  word when at_last is high and shift_en is applied)
//   at_last      : the next sampled bit is the final bit of the word; a
//                  sample taken while at_last is high is the done pulse
//
// Bits enter at the MSB end and move right, so after WIDTH samples bit 0
// of the serial word sits in bit 0 of the register. The outputs depend only
// on flops and bit_in so the controlling FSM can consume them in its own
// combinational process without forming a loop through this module.
module serial_capture #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             bit_in,
    output logic [WIDTH-1:0] shifted_word,
    output logic             at_last
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign shifted_word = {bit_in, sr_q[WIDTH-1:1]};
    assign at_last      = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (start) begin
            sr_d  = {bit_in, {(WIDTH-1){1'b0}}};
            cnt_d = CNT_W'(1);
        end else if (shift_en) begin
            sr_d  = shifted_word;
            // Wrap to zero after the final bit; the word has been handed off.
            cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/order_decoder.sv
// Order decoder: captures the 18-bit serial order (LSB first) during
// Stage 2 of main control (g13), holds it under a valid/ack handshake and
// presents the decoded fields.
//   clk, rst    : clock, synchronous active-high reset
//   order       : serial order bit, bit 0 in the word_start cycle
//   word_start  : marks bit 0 of each serial word
//   g13         : Stage 2 of main control
//   order_ack   : main control consumed the held order
//   order_valid : decoded order held and stable
//   order_word  : last captured order
//   opcode, spare, tank_num, position, half_mc, long_num : field slices
//   illegal_op  : opcode not in LEGAL_MASK, only while order_valid
//   busy        : serial capture in progress
module order_decoder
    import order_decoder_pkg::*;
#(
    parameter int          WORD_WIDTH = ORDER_BITS,
    parameter logic [31:0] LEGAL_MASK = DEFAULT_LEGAL_MASK
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  order,
    input  logic                  word_start,
    input  logic                  g13,
    input  logic                  order_ack,
    output logic                  order_valid,
    output logic [WORD_WIDTH-1:0] order_word,
    output logic [4:0]            opcode,
    output logic                  spare,
    output logic [4:0]            tank_num,
    output logic [3:0]            position,
    output logic                  half_mc,
    output logic                  long_num,
    output logic                  illegal_op,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic                  armed_q, armed_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;

    logic                  cap_start, cap_shift, cap_clear;
    logic [WORD_WIDTH-1:0] cap_word;
    logic                  cap_last;

    serial_capture #(.WIDTH(WORD_WIDTH)) u_capture (
        .clk          (clk),
        .rst          (rst),
        .start        (cap_start),
        .shift_en     (cap_shift),
        .clear        (cap_clear),
        .bit_in       (order),
        .shifted_word (cap_word),
        .at_last      (cap_last)
    );

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        word_d    = word_q;
        cap_start = 1'b0;
        cap_shift = 1'b0;
        cap_clear = 1'b0;

        // Leaving Stage 2 re-arms, so each Stage 2 entry gets one capture
        // and a recirculating order is not decoded twice.
        if (!g13) armed_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (word_start && g13 && armed_q) begin
                    cap_start = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (!g13) begin
                    cap_clear = 1'b1;
                    state_d   = IDLE;
                end else if (word_start) begin
                    // Resynchronise: this cycle's bit becomes bit 0.
                    cap_start = 1'b1;
                end else begin
                    cap_shift = 1'b1;
                    if (cap_last) begin
                        word_d  = cap_word;
                        state_d = HOLD;
                        armed_d = 1'b0;
                    end
                end
            end
            HOLD: begin
                // word_start is deliberately ignored here, even with ack.
                if (order_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            armed_q <= 1'b1;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            word_q  <= word_d;
        end
    end

    assign order_valid = (state_q == HOLD);
    assign busy        = (state_q == SHIFT);
    assign order_word  = word_q;
    assign opcode      = word_q[OP_LSB +: 5];
    assign spare       = word_q[SPARE_BIT];
    assign tank_num    = word_q[TANK_LSB +: 5];
    assign position    = word_q[POS_LSB +: 4];
    assign half_mc     = word_q[HALF_BIT];
    assign long_num    = word_q[LONG_BIT];
    assign illegal_op  = order_valid && !LEGAL_MASK[opcode];

endmodule

// File: tb/tb_order_decoder.sv
// Directed bench for order_decoder. Two instances share stimulus: one with
// every opcode legal, one with opcode 28 illegal. Inputs change 1 time unit
// after the rising edge; outputs (pure functions of flops) are checked there.
module tb_order_decoder;

    logic clk = 1'b0;
    logic rst, order, word_start, g13, order_ack;

    logic        a_valid, a_spare, a_half, a_long, a_illegal, a_busy;
    logic [17:0] a_word;
    logic [4:0]  a_opcode, a_tank;
    logic [3:0]  a_pos;

    logic        b_valid, b_spare, b_half, b_long, b_illegal, b_busy;
    logic [17:0] b_word;
    logic [4:0]  b_opcode, b_tank;
    logic [3:0]  b_pos;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    order_decoder dut_a (
        .clk(clk), .rst(rst), .order(order), .word_start(word_start),
        .g13(g13), .order_ack(order_ack),
        .order_valid(a_valid), .order_word(a_word), .opcode(a_opcode),
        .spare(a_spare), .tank_num(a_tank), .position(a_pos),
        .half_mc(a_half), .long_num(a_long), .illegal_op(a_illegal),
        .busy(a_busy)
    );

    order_decoder #(.LEGAL_MASK(32'hEFFF_FFFF)) dut_b (
        .clk(clk), .rst(rst), .order(order), .word_start(word_start),
        .g13(g13), .order_ack(order_ack),
        .order_valid(b_valid), .order_word(b_word), .opcode(b_opcode),
        .spare(b_spare), .tank_num(b_tank), .position(b_pos),
        .half_mc(b_half), .long_num(b_long), .illegal_op(b_illegal),
        .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive bits first..last of w, one per cycle; word_start on the first
    // driven bit when ws is set.
    task automatic send_bits(input logic [17:0] w, input int first, input int last, input bit ws);
        for (int k = first; k <= last; k++) begin
            order      = w[k];
            word_start = ws && (k == first);
            tick();
        end
        word_start = 1'b0;
        order      = 1'b0;
    endtask

    task automatic rearm();
        g13 = 1'b0;
        tick();
        g13 = 1'b1;
    endtask

    initial begin
        rst = 1'b1; order = 1'b0; word_start = 1'b0; g13 = 1'b0; order_ack = 1'b0;
        tick();
        tick();
        chk("reset_valid", a_valid, 0);
        chk("reset_word", a_word, 0);
        chk("reset_busy", a_busy, 0);
        chk("reset_illegal", b_illegal, 0);
        rst = 1'b0;
        g13 = 1'b1;
        tick();

        // Basic capture of 18'h381AA, valid exactly 18 cycles after start.
        send_bits(18'h381AA, 0, 16, 1'b1);
        chk("cap1_busy", a_busy, 1);
        chk("cap1_not_early", a_valid, 0);
        send_bits(18'h381AA, 17, 17, 1'b0);
        chk("cap1_valid", a_valid, 1);
        chk("cap1_busy_off", a_busy, 0);
        chk("cap1_word", a_word, 32'h381AA);
        chk("cap1_opcode", a_opcode, 28);
        chk("cap1_tank", a_tank, 3);
        chk("cap1_pos", a_pos, 5);
        chk("cap1_half", a_half, 0);
        chk("cap1_long", a_long, 1);
        chk("cap1_spare", a_spare, 0);
        chk("cap1_legal", a_illegal, 0);
        chk("cap1_illegal_b", b_illegal, 1);
        chk("cap1_valid_b", b_valid, 1);
        tick();
        chk("cap1_still_valid", a_valid, 1);
        order_ack = 1'b1;
        tick();
        order_ack = 1'b0;
        chk("ack_valid_drop", a_valid, 0);
        chk("ack_illegal_drop", b_illegal, 0);
        chk("ack_fields_hold", a_tank, 3);

        // Still in the same Stage 2: recirculating words must not re-decode.
        for (int r = 0; r < 3; r++) begin
            send_bits(18'h381AA, 0, 17, 1'b1);
            chk("recirc_no_valid", a_valid, 0);
            chk("recirc_no_busy", a_busy, 0);
        end

        // Re-arm and capture a new word; g13 drop in HOLD keeps the hold.
        rearm();
        send_bits(18'h0F0F3, 0, 17, 1'b1);
        chk("cap2_valid", a_valid, 1);
        chk("cap2_word", a_word, 32'h0F0F3);
        chk("cap2_opcode", a_opcode, 7);
        g13 = 1'b0;
        tick();
        tick();
        chk("hold_g13_low", a_valid, 1);
        chk("hold_g13_word", a_word, 32'h0F0F3);
        g13 = 1'b1;
        order_ack = 1'b1;
        tick();
        order_ack = 1'b0;
        chk("cap2_acked", a_valid, 0);

        // Abort: g13 drops while bit 9 is on the line.
        rearm();
        send_bits(18'h2AAAA, 0, 8, 1'b1);
        chk("abort_busy_before", a_busy, 1);
        g13   = 1'b0;
        order = 1'b1;
        tick();
        chk("abort_busy_fall", a_busy, 0);
        for (int k = 0; k < 10; k++) tick();
        chk("abort_no_valid", a_valid, 0);
        chk("abort_word_kept", a_word, 32'h0F0F3);
        g13 = 1'b1;

        // Resync: second word_start at bit 6, then clean 18'h00002.
        send_bits(18'h381AA, 0, 5, 1'b1);
        send_bits(18'h00002, 0, 16, 1'b1);
        chk("resync_not_early", a_valid, 0);
        send_bits(18'h00002, 17, 17, 1'b0);
        chk("resync_valid", a_valid, 1);
        chk("resync_word", a_word, 32'h00002);
        chk("resync_long", a_long, 1);
        chk("resync_opcode", a_opcode, 0);
        chk("resync_tank", a_tank, 0);
        chk("resync_pos", a_pos, 0);
        chk("resync_half", a_half, 0);
        chk("resync_spare", a_spare, 0);
        chk("resync_legal_b", b_illegal, 0);

        // ack and word_start together in HOLD: ack wins, no new capture.
        order_ack  = 1'b1;
        word_start = 1'b1;
        order      = 1'b1;
        tick();
        order_ack  = 1'b0;
        word_start = 1'b0;
        chk("simul_valid", a_valid, 0);
        chk("simul_busy", a_busy, 0);
        send_bits(18'h3FFFF, 0, 17, 1'b1);
        chk("simul_no_recapture", a_valid, 0);
        chk("simul_word_kept", a_word, 32'h00002);

        // Reset while bit 12 is on the line.
        rearm();
        send_bits(18'h381AA, 0, 11, 1'b1);
        chk("rst_mid_busy", a_busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy_off", a_busy, 0);
        chk("rst_mid_valid", a_valid, 0);
        chk("rst_mid_word", a_word, 0);
        chk("rst_mid_long", a_long, 0);
        for (int k = 0; k < 8; k++) tick();
        chk("rst_mid_stays_idle", a_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
